// File: rtl/mem_pkg.sv
// Shared definitions for the backing-memory responder and the cache controller
// that talks to it.
package mem_pkg;

   localparam int WORD_W          = 32;
   localparam int BE_W            = 4;
   localparam int DEFAULT_LATENCY = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic [AW-1:0]     addr,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // NOTE: storage and its read register carry no reset so the array maps onto
   // RAM macros; contents survive a reset of the surrounding logic.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_backing_resp.sv
// Backing-memory responder: accepts one read or write at a time and completes it
// after LATENCY cycles with a one-cycle memsig pulse.
module mem_backing_resp
   import mem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WORD_W-1:0]   address,
   input  logic [WORD_W-1:0]   datain,
   input  logic                ren,
   input  logic                wen,
   input  logic [BE_W-1:0]     byte_selector,
   output logic [WORD_W-1:0]   dataout,
   output logic                memsig
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            CW       = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [AW-1:0]       addr_q;
   logic [WORD_W-1:0]   data_q;
   logic [BE_W-1:0]     be_q;
   logic                wr_q;
   logic                rd_valid;
   logic                accept;

   logic                op_wr;
   logic [AW-1:0]       arr_addr;
   logic [WORD_W-1:0]   arr_wdata;
   logic [BE_W-1:0]     arr_be;
   logic                arr_we, arr_re;
   logic [WORD_W-1:0]   arr_rdata;

   // Address bits above the array index are deliberately ignored (wrap).
   wire unused_addr_hi = ^address[WORD_W-1:AW];

   assign accept = (state == IDLE) && (ren || wen);

   // NOTE: every signal driven here gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (ren || wen) begin
               cnt_nxt   = CNT_LOAD;
               state_nxt = (LATENCY == 1) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt == CW'(1)) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // In IDLE the live request is what gets latched this edge; with LATENCY=1 the
   // array must act on it at that same edge, so it bypasses the latches.
   always_comb begin
      op_wr     = (state == IDLE) ? wen                      : wr_q;
      arr_addr  = (state == IDLE) ? address[AW-1:0]          : addr_q;
      arr_wdata = (state == IDLE) ? datain                   : data_q;
      arr_be    = (state == IDLE) ? byte_selector            : be_q;
      arr_we    = (state_nxt == DONE) && (state != DONE) &&  op_wr;
      arr_re    = (state_nxt == DONE) && (state != DONE) && !op_wr;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         memsig   <= 1'b0;
         rd_valid <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         be_q     <= '0;
         wr_q     <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         memsig <= (state_nxt == DONE) && (state != DONE);
         if (arr_re) rd_valid <= 1'b1;
         if (accept) begin
            addr_q <= address[AW-1:0];
            data_q <= datain;
            be_q   <= byte_selector;
            wr_q   <= wen;
         end
      end
   end

   // The RAM read register has no reset; rd_valid (a flop) masks it to zero
   // until the first read completes after reset.
   assign dataout = rd_valid ? arr_rdata : '0;

   mem_word_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .addr  (arr_addr),
      .we    (arr_we),
      .be    (arr_be),
      .wdata (arr_wdata),
      .re    (arr_re),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_mem_backing_resp.sv
// Self-checking bench: a LATENCY=4 and a LATENCY=1 responder checked against a
// word-array model with directed and randomized transactions.
module tb_mem_backing_resp;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address, datain;
   logic [3:0]  byte_selector;
   logic        ren_a, wen_a, ren_b, wen_b;
   logic [31:0] dataout_a, dataout_b;
   logic        memsig_a, memsig_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];
   logic [31:0] dout_a, dout_b;

   always #5 clk = ~clk;

   mem_backing_resp #(.DEPTH(DEPTH), .LATENCY(4)) dut_a (
      .clk(clk), .reset(reset), .address(address), .datain(datain),
      .ren(ren_a), .wen(wen_a), .byte_selector(byte_selector),
      .dataout(dataout_a), .memsig(memsig_a)
   );

   mem_backing_resp #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
      .clk(clk), .reset(reset), .address(address), .datain(datain),
      .ren(ren_b), .wen(wen_b), .byte_selector(byte_selector),
      .dataout(dataout_b), .memsig(memsig_b)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic get_ms(input int sel);
      return (sel == 0) ? memsig_a : memsig_b;
   endfunction

   function automatic logic [31:0] get_do(input int sel);
      return (sel == 0) ? dataout_a : dataout_b;
   endfunction

   function automatic logic [31:0] model_do(input int sel);
      return (sel == 0) ? dout_a : dout_b;
   endfunction

   task automatic set_req(input int sel, input logic r, input logic w);
      if (sel == 0) begin ren_a = r; wen_a = w; end
      else          begin ren_b = r; wen_b = w; end
   endtask

   // Counts rising edges until memsig is seen at a falling edge; held dataout is
   // checked on every cycle without a pulse.
   task automatic wait_pulse(input int sel, input bit perturb, output int n);
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (get_ms(sel)) break;
         check("dataout_hold", get_do(sel), model_do(sel));
         if (perturb && n == 1) begin
            address       = $urandom;
            datain        = $urandom;
            byte_selector = 4'($urandom);
         end
      end
   endtask

   // One transaction, started at a falling edge. With then_rd, ren stays held
   // after the write so a separate read of the same word follows.
   task automatic txn(input int sel, input bit is_wr, input bit then_rd,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input bit perturb, input string tag);
      int lat = (sel == 0) ? 4 : 1;
      int idx = int'(a % 32'(DEPTH));
      int n;
      logic [31:0] exp_rd;
      address       = a;
      datain        = d;
      byte_selector = be;
      set_req(sel, !is_wr || then_rd, is_wr);
      wait_pulse(sel, perturb, n);
      check({tag, "/latency"}, 32'(n), 32'(lat));
      if (is_wr) begin
         if (sel == 0) mem_a[idx] = merge(mem_a[idx], d, be);
         else          mem_b[idx] = merge(mem_b[idx], d, be);
         check({tag, "/wr_keeps_dataout"}, get_do(sel), model_do(sel));
      end else begin
         exp_rd = (sel == 0) ? mem_a[idx] : mem_b[idx];
         if (sel == 0) dout_a = exp_rd; else dout_b = exp_rd;
         check({tag, "/rdata"}, get_do(sel), exp_rd);
      end
      set_req(sel, then_rd, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "/pulse_width"}, 32'(get_ms(sel)), 32'(0));
      if (then_rd) begin
         wait_pulse(sel, 1'b0, n);
         check({tag, "/rd_spacing"}, 32'(n + 1), 32'(lat + 1));
         exp_rd = (sel == 0) ? mem_a[idx] : mem_b[idx];
         if (sel == 0) dout_a = exp_rd; else dout_b = exp_rd;
         check({tag, "/rd_after_wr"}, get_do(sel), exp_rd);
         set_req(sel, 1'b0, 1'b0);
         @(posedge clk);
         @(negedge clk);
         check({tag, "/rd_pulse_width"}, 32'(get_ms(sel)), 32'(0));
      end
   endtask

   initial begin
      reset = 1'b0;
      address = '0; datain = '0; byte_selector = '0;
      ren_a = 0; wen_a = 0; ren_b = 0; wen_b = 0;
      dout_a = '0; dout_b = '0;
      repeat (3) @(negedge clk);
      check("rst/memsig_a",  32'(memsig_a), 32'(0));
      check("rst/dataout_a", dataout_a, 32'h0);
      check("rst/memsig_b",  32'(memsig_b), 32'(0));
      check("rst/dataout_b", dataout_b, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Preload and first read: dataout stays 0 until the read completes.
      txn(0, 1, 0, 32'd5, 32'hDEADBEEF, 4'hF, 0, "preload5");
      txn(0, 0, 0, 32'd5, 32'h0, 4'h0, 0, "read5");
      check("read5/value", dataout_a, 32'hDEADBEEF);

      // Partial write, then an empty-mask write that must change nothing.
      txn(0, 1, 0, 32'd7, 32'h11223344, 4'hF, 0, "preload7");
      txn(0, 1, 0, 32'd7, 32'hAABBCCDD, 4'b0101, 0, "partial7");
      txn(0, 0, 0, 32'd7, 32'h0, 4'h0, 0, "read7");
      check("partial7/value", dataout_a, 32'h11BB33DD);
      txn(0, 1, 0, 32'd7, 32'hFFFFFFFF, 4'b0000, 0, "nomask7");
      txn(0, 0, 0, 32'd7, 32'h0, 4'h0, 0, "reread7");
      check("nomask7/value", dataout_a, 32'h11BB33DD);

      // Write-back then refill with both requests asserted together.
      txn(0, 1, 1, 32'd3, 32'h0000CAFE, 4'hF, 0, "wr_rd3");
      check("wr_rd3/value", dataout_a, 32'h0000CAFE);

      // Inputs changing while busy must not affect the transaction.
      txn(0, 1, 0, 32'd9, 32'h55667788, 4'hF, 1, "pert_wr9");
      txn(0, 0, 0, 32'd9, 32'h0, 4'h0, 1, "pert_rd9");
      check("pert9/value", dataout_a, 32'h55667788);

      // Reset two cycles into a read.
      address = 32'd7;
      set_req(0, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst/memsig_a",  32'(memsig_a), 32'(0));
      check("midrst/dataout_a", dataout_a, 32'h0);
      check("midrst/dataout_b", dataout_b, 32'h0);
      set_req(0, 1'b0, 1'b0);
      dout_a = '0;
      dout_b = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("midrst/no_pulse", 32'(memsig_a), 32'(0));
         check("midrst/dout_zero", dataout_a, 32'h0);
      end
      txn(0, 0, 0, 32'd7, 32'h0, 4'h0, 0, "reissue7");
      check("reissue7/value", dataout_a, 32'h11BB33DD);

      // LATENCY=1 instance: address wrap and back-to-back write/read.
      txn(1, 1, 0, 32'd2, 32'h0BADF00D, 4'hF, 0, "b_wr2");
      txn(1, 0, 0, 32'(DEPTH + 2), 32'h0, 4'h0, 0, "b_wrap");
      check("b_wrap/value", dataout_b, 32'h0BADF00D);
      txn(1, 0, 0, (32'd7 << 10) | 32'd2, 32'h0, 4'h0, 0, "b_wrap_hi");
      txn(1, 1, 1, 32'd11, 32'h12345678, 4'b1100, 0, "b_wr_rd11");

      // Randomized traffic over a small window of words with random upper bits.
      for (int i = 0; i < 8; i++)
         txn(0, 1, 0, ($urandom << 10) | 32'(16 + i), $urandom, 4'hF, 0, "rnd_init");
      for (int i = 0; i < 24; i++)
         txn(0, 1'($urandom), 0, ($urandom << 10) | 32'(16 + $urandom_range(0, 7)),
             $urandom, 4'($urandom), 1'($urandom), "rnd");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
